// File: rtl/lbm_phase_sched.sv
// lbm_phase_sched: LBM timestep sequencer driving collide, stream and boundary sweeps.
// Optional abort path is built when LBM_SCHED_ABORT_EN is defined.
module lbm_phase_sched #(
  parameter int GRID_W        = 16,
  parameter int GRID_DIM      = GRID_W * GRID_W,
  parameter int ADDRESS_WIDTH = $clog2(GRID_DIM),
  parameter int MEM_LATENCY   = 2,
  parameter int STEP_WIDTH    = 16
) (
  input  logic                     Clk,
  input  logic                     Reset,
  input  logic                     Start,
  input  logic [STEP_WIDTH-1:0]    Num_steps,
  input  logic                     Stall,
`ifdef LBM_SCHED_ABORT_EN
  input  logic                     Abort,
`endif
  output logic [ADDRESS_WIDTH-1:0] address,
  output logic                     addr_valid,
  output logic [1:0]               phase,
  output logic                     bank_sel,
  output logic                     busy,
  output logic                     done,
  output logic [STEP_WIDTH-1:0]    step_count
);

  localparam int XW = $clog2(GRID_W);
  localparam int CW = $clog2(MEM_LATENCY + 1);

  localparam logic [XW-1:0] X_MAX = XW'(GRID_W - 1);
  localparam logic [XW-1:0] X_ONE = XW'(1);
  localparam logic [ADDRESS_WIDTH-1:0] A_LAST = ADDRESS_WIDTH'(GRID_DIM - 1);
  localparam logic [ADDRESS_WIDTH-1:0] A_JUMP = ADDRESS_WIDTH'(GRID_W - 1);
  localparam logic [ADDRESS_WIDTH-1:0] A_ONE  = ADDRESS_WIDTH'(1);
  localparam logic [CW-1:0] C_LOAD = CW'(MEM_LATENCY);
  localparam logic [CW-1:0] C_ONE  = CW'(1);
  localparam logic [STEP_WIDTH-1:0] S_ONE = STEP_WIDTH'(1);

  localparam logic [1:0] PH_IDLE = 2'd0;
  localparam logic [1:0] PH_COL  = 2'd1;
  localparam logic [1:0] PH_STR  = 2'd2;
  localparam logic [1:0] PH_BC   = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_COLLIDE,
    S_STREAM,
    S_BC,
    S_DRAIN
  } state_t;

  state_t                   state, state_n;
  logic [XW-1:0]            x, x_n;
  logic [XW-1:0]            y, y_n;
  logic [ADDRESS_WIDTH-1:0] address_n;
  logic [1:0]               phase_n;
  logic                     bank_n;
  logic                     busy_n;
  logic                     done_n;
  logic [STEP_WIDTH-1:0]    step_n;
  logic [STEP_WIDTH-1:0]    step_inc;
  logic [CW-1:0]            cnt, cnt_n;
  logic [STEP_WIDTH-1:0]    target, target_n;
`ifdef LBM_SCHED_ABORT_EN
  logic                     abort_q, abort_n;
`endif

  logic sweep;
  logic last;
  logic edge_row;
  logic jump;
  logic wrap;

  assign sweep = (state == S_COLLIDE) || (state == S_STREAM) ||
                 (state == S_BC);
  assign addr_valid = sweep && !Stall;

  assign last     = (address == A_LAST);
  assign edge_row = (y == '0) || (y == X_MAX);
  // Interior rows of the BC sweep skip straight from the left to the right edge.
  assign jump     = (state == S_BC) && !edge_row && (x == '0);
  assign wrap     = (x == X_MAX);
  assign step_inc = step_count + S_ONE;

  always_comb begin
    state_n   = state;
    x_n       = x;
    y_n       = y;
    address_n = address;
    phase_n   = phase;
    bank_n    = bank_sel;
    busy_n    = busy;
    done_n    = 1'b0;
    step_n    = step_count;
    cnt_n     = cnt;
    target_n  = target;
`ifdef LBM_SCHED_ABORT_EN
    abort_n   = abort_q;
`endif
    unique case (state)
      S_IDLE: begin
        address_n = '0;
        if (Start) begin
          if (Num_steps != '0) begin
            target_n  = Num_steps;
            step_n    = '0;
            x_n       = '0;
            y_n       = '0;
            busy_n    = 1'b1;
            phase_n   = PH_COL;
            state_n   = S_COLLIDE;
          end else begin
            done_n = 1'b1;
          end
        end
      end
      S_COLLIDE, S_STREAM, S_BC: begin
        if (!Stall) begin
          if (last) begin
            state_n = S_DRAIN;
            cnt_n   = C_LOAD;
          end else if (jump) begin
            x_n       = X_MAX;
            address_n = address + A_JUMP;
          end else if (wrap) begin
            x_n       = '0;
            y_n       = y + X_ONE;
            address_n = address + A_ONE;
          end else begin
            x_n       = x + X_ONE;
            address_n = address + A_ONE;
          end
        end
      end
      S_DRAIN: begin
        if (cnt == C_ONE) begin
          x_n       = '0;
          y_n       = '0;
          address_n = '0;
          unique case (phase)
            PH_COL: begin
              state_n = S_STREAM;
              phase_n = PH_STR;
            end
            PH_STR: begin
              state_n = S_BC;
              phase_n = PH_BC;
            end
            default: begin
              bank_n = ~bank_sel;
              step_n = step_inc;
              if (step_inc == target) begin
                state_n = S_IDLE;
                phase_n = PH_IDLE;
                busy_n  = 1'b0;
                done_n  = 1'b1;
              end else begin
                state_n = S_COLLIDE;
                phase_n = PH_COL;
              end
            end
          endcase
`ifdef LBM_SCHED_ABORT_EN
          // An aborted step leaves the bank and step count untouched.
          if (abort_q) begin
            state_n = S_IDLE;
            phase_n = PH_IDLE;
            busy_n  = 1'b0;
            done_n  = 1'b0;
            bank_n  = bank_sel;
            step_n  = step_count;
            abort_n = 1'b0;
          end
`endif
        end else begin
          cnt_n = cnt - C_ONE;
        end
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase
`ifdef LBM_SCHED_ABORT_EN
    if (Abort && (state != S_IDLE)) begin
      state_n   = S_DRAIN;
      cnt_n     = C_LOAD;
      abort_n   = 1'b1;
      x_n       = x;
      y_n       = y;
      address_n = address;
      phase_n   = phase;
      bank_n    = bank_sel;
      step_n    = step_count;
      busy_n    = busy;
      done_n    = 1'b0;
    end
`endif
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state      <= S_IDLE;
      x          <= '0;
      y          <= '0;
      address    <= '0;
      phase      <= PH_IDLE;
      bank_sel   <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      step_count <= '0;
      cnt        <= '0;
      target     <= '0;
`ifdef LBM_SCHED_ABORT_EN
      abort_q    <= 1'b0;
`endif
    end else begin
      state      <= state_n;
      x          <= x_n;
      y          <= y_n;
      address    <= address_n;
      phase      <= phase_n;
      bank_sel   <= bank_n;
      busy       <= busy_n;
      done       <= done_n;
      step_count <= step_n;
      cnt        <= cnt_n;
      target     <= target_n;
`ifdef LBM_SCHED_ABORT_EN
      abort_q    <= abort_n;
`endif
    end
  end

endmodule

// File: tb/tb_lbm_phase_sched.sv
// tb_lbm_phase_sched: randomized bench for lbm_phase_sched against a queue model.
// Each model entry is one expected cycle: a sweep node, a drain cycle, or a done pulse.
module tb_lbm_phase_sched;

  localparam int W   = 16;
  localparam int DIM = W * W;
  localparam int LAT = 2;
  localparam int AW  = $clog2(DIM);
  localparam int SW  = 16;

  localparam int K_NODE  = 0;
  localparam int K_DRAIN = 1;
  localparam int K_DONE  = 2;

  logic          Clk = 1'b0;
  logic          Reset = 1'b0;
  logic          Start = 1'b0;
  logic          Stall = 1'b0;
  logic [SW-1:0] Num_steps = '0;
`ifdef LBM_SCHED_ABORT_EN
  logic          Abort = 1'b0;
`endif
  logic [AW-1:0] address;
  logic          addr_valid;
  logic [1:0]    phase;
  logic          bank_sel;
  logic          busy;
  logic          done;
  logic [SW-1:0] step_count;

  always #5 Clk = ~Clk;

  lbm_phase_sched #(
    .GRID_W(W),
    .MEM_LATENCY(LAT),
    .STEP_WIDTH(SW)
  ) dut (
    .Clk(Clk),
    .Reset(Reset),
    .Start(Start),
    .Num_steps(Num_steps),
    .Stall(Stall),
`ifdef LBM_SCHED_ABORT_EN
    .Abort(Abort),
`endif
    .address(address),
    .addr_valid(addr_valid),
    .phase(phase),
    .bank_sel(bank_sel),
    .busy(busy),
    .done(done),
    .step_count(step_count)
  );

  typedef struct {
    int kind;
    int ph;
    int addr;
    int bank;
    int step;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   done_cyc = -1;
  int   run_s = 0;
  int   mbank = 0;
  int   mstep = 0;
  bit   chk_en = 1'b0;
  bit   stall_rand = 1'b0;

  function automatic void chk(input string name, input int act, input int want);
    total++;
    if (act != want) begin
      bad++;
      $display("FAIL %s: got %0d want %0d (cycle %0d)", name, act, want, cyc);
    end
  endfunction

  function automatic exp_t mk(input int kind, input int ph, input int addr);
    exp_t e;
    e.kind = kind;
    e.ph   = ph;
    e.addr = addr;
    e.bank = mbank;
    e.step = mstep;
    return e;
  endfunction

  function automatic bit boundary(input int a);
    int xx;
    int yy;
    xx = a % W;
    yy = a / W;
    return (xx == 0) || (xx == W - 1) || (yy == 0) || (yy == W - 1);
  endfunction

  // Full expected cycle trace of one run, from cycle 1 through the done pulse.
  function automatic void plan_run(input int n);
    mstep = 0;
    for (int s = 0; s < n; s++) begin
      for (int ph = 1; ph <= 3; ph++) begin
        for (int a = 0; a < DIM; a++)
          if (ph != 3 || boundary(a)) q.push_back(mk(K_NODE, ph, a));
        for (int d = 0; d < LAT; d++) q.push_back(mk(K_DRAIN, ph, 0));
      end
      mbank = mbank ^ 1;
      mstep = mstep + 1;
    end
    q.push_back(mk(K_DONE, 0, 0));
  endfunction

  always @(negedge Clk) begin
    exp_t e;
    cyc++;
    if (chk_en) begin
      if (q.size() == 0) begin
        chk("idle_valid", int'(addr_valid), 0);
        chk("idle_phase", int'(phase), 0);
        chk("idle_addr", int'(address), 0);
        chk("idle_busy", int'(busy), 0);
        chk("idle_done", int'(done), 0);
        chk("idle_bank", int'(bank_sel), mbank);
        chk("idle_step", int'(step_count), mstep);
      end else begin
        e = q[0];
        chk("bank", int'(bank_sel), e.bank);
        chk("step", int'(step_count), e.step);
        chk("phase", int'(phase), e.ph);
        chk("busy", int'(busy), (e.kind == K_DONE) ? 0 : 1);
        chk("done", int'(done), (e.kind == K_DONE) ? 1 : 0);
        chk("valid", int'(addr_valid),
            (e.kind == K_NODE) ? int'(!Stall) : 0);
        if (e.kind != K_DRAIN) chk("addr", int'(address), e.addr);
        if (e.kind == K_DONE && done) done_cyc = cyc;
        if (e.kind != K_NODE || !Stall) void'(q.pop_front());
      end
    end
  end

  always @(posedge Clk) begin
    if (stall_rand) begin
      #1;
      Stall = ($urandom_range(0, 3) == 0);
    end
  end

  task automatic begin_run(input int n);
    @(posedge Clk);
    #1;
    Start = 1'b1;
    Num_steps = SW'(n);
    done_cyc = -1;
    run_s = cyc + 1;
    @(posedge Clk);
    #1;
    Start = 1'b0;
    Num_steps = SW'($urandom);
    plan_run(n);
  endtask

  task automatic wait_empty(input int budget);
    int i;
    i = 0;
    while (q.size() != 0 && i < budget) begin
      @(posedge Clk);
      i++;
    end
    if (q.size() != 0) begin
      chk("timeout_left", q.size(), 0);
      q.delete();
    end
    @(posedge Clk);
  endtask

  task automatic finish_run(input int n, input int len);
    wait_empty(n * 2000 + 100);
    if (len > 0) chk("run_len", done_cyc - run_s, len);
  endtask

  task automatic wait_node(input int ph, input int addr);
    for (int i = 0; i < 3000; i++) begin
      @(posedge Clk);
      #1;
      if (q.size() != 0 && q[0].kind == K_NODE && q[0].ph == ph &&
          q[0].addr == addr) break;
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_addr"}, int'(address), 0);
    chk({tag, "_phase"}, int'(phase), 0);
    chk({tag, "_bank"}, int'(bank_sel), 0);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_done"}, int'(done), 0);
    chk({tag, "_step"}, int'(step_count), 0);
    chk({tag, "_valid"}, int'(addr_valid), 0);
  endtask

  initial begin
    int n;
    int bc;
    exp_t e;
    #2 Reset = 1'b1;
    #1 chk_zero("rst");
    @(posedge Clk);
    @(posedge Clk);
    #1 Reset = 1'b0;
    chk_en = 1'b1;

    // single step, no stall; pin the model trace shape by hand
    begin_run(1);
    chk("pin_len", q.size(), 579);
    bc = 0;
    foreach (q[i]) if (q[i].kind == K_NODE && q[i].ph == 3) bc++;
    chk("pin_bc_cnt", bc, 60);
    chk("pin_bc_first_ph", q[516].ph, 3);
    chk("pin_bc_16", q[532].addr, 16);
    chk("pin_bc_17", q[533].addr, 31);
    chk("pin_bc_last", q[575].addr, 255);
    chk("pin_done_kind", q[578].kind, K_DONE);
    finish_run(1, 579);

    // Num_steps = 0: done pulse only, step count untouched
    @(posedge Clk);
    #1;
    Start = 1'b1;
    Num_steps = '0;
    @(posedge Clk);
    #1;
    Start = 1'b0;
    q.push_back(mk(K_DONE, 0, 0));
    wait_empty(10);
    repeat (3) @(posedge Clk);

    // three steps with a Start pulse mid-run
    begin_run(3);
    repeat ($urandom_range(50, 1200)) @(posedge Clk);
    #1;
    Start = 1'b1;
    Num_steps = SW'(7);
    @(posedge Clk);
    #1;
    Start = 1'b0;
    finish_run(3, 3 * 578 + 1);

    // five-cycle stall at collide address 100
    begin_run(1);
    wait_node(1, 100);
    Stall = 1'b1;
    repeat (5) @(posedge Clk);
    #1 Stall = 1'b0;
    finish_run(1, 584);

    // random stalls over random step counts
    for (int r = 0; r < 2; r++) begin
      n = $urandom_range(1, 2);
      stall_rand = 1'b1;
      begin_run(n);
      finish_run(n, 0);
      stall_rand = 1'b0;
      @(posedge Clk);
      #2 Stall = 1'b0;
    end

    // asynchronous reset in the middle of the stream sweep
    begin_run(1);
    wait_node(2, $urandom_range(5, 200));
    #2 Reset = 1'b1;
    #1 chk_zero("mid_rst");
    q.delete();
    mbank = 0;
    mstep = 0;
    @(posedge Clk);
    @(posedge Clk);
    #1 Reset = 1'b0;
    begin_run(1);
    finish_run(1, 579);

`ifdef LBM_SCHED_ABORT_EN
    // abort at BC address 31: two drain cycles then idle, no done
    begin_run(1);
    wait_node(3, 31);
    Abort = 1'b1;
    e = q[0];
    q.delete();
    q.push_back(e);
    mbank = e.bank;
    mstep = e.step;
    q.push_back(mk(K_DRAIN, 3, 0));
    q.push_back(mk(K_DRAIN, 3, 0));
    @(posedge Clk);
    #1 Abort = 1'b0;
    wait_empty(20);
    repeat (3) @(posedge Clk);
`endif

    repeat (3) @(posedge Clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    bad++;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/lbm_phase_sched.md
Name: lbm_phase_sched

Overview:
- Top-level timestep sequencer for the LBM engine.
- Runs a programmed number of timesteps; each timestep is a full-grid COLLIDE sweep, a full-grid STREAM sweep, then a boundary-only BC sweep.
- Generates node addresses, a per-node valid, and the phase code, and flips the distribution-memory ping-pong bank after each timestep.
- Sits between the host start/done handshake and the collision, streaming and boundary-condition datapaths.

Parameters:
- GRID_W, 16, lattice width = height (nodes per row); must be at least 3.
- GRID_DIM, GRID_W*GRID_W, total nodes.
- ADDRESS_WIDTH, $clog2(GRID_DIM), node address width.
- MEM_LATENCY, 2, drain cycles after each sweep for the datapath pipeline to empty; must be at least 1.
- STEP_WIDTH, 16, width of the step count.

Ports:
- Clk  in  1  system clock.
- Reset  in  1  asynchronous, active-high reset.
- Start  in  1  begin run; sampled only in IDLE.
- Num_steps  in  STEP_WIDTH  timesteps to run; latched when Start is accepted.
- Stall  in  1  memory back-pressure; freezes the address iterator.
- address  out  ADDRESS_WIDTH  current node address (y*GRID_W + x).
- addr_valid  out  1  address is issued this cycle.
- phase  out  2  0 idle, 1 collide, 2 stream, 3 bc.
- bank_sel  out  1  ping-pong source bank; destination is ~bank_sel.
- busy  out  1  run in progress.
- done  out  1  one-cycle pulse when a run completes.
- step_count  out  STEP_WIDTH  timesteps completed in the current run.

Behaviour:
- Reset (async): state IDLE; address, phase, bank_sel, busy, done and step_count all 0; x and y counters 0; drain counter 0.
- All outputs are registered except addr_valid.
- addr_valid = (state is COLLIDE, STREAM or BC) & ~Stall; combinational.
- States: IDLE, COLLIDE, STREAM, BC, DRAIN.
  - DRAIN holds phase at the value of the sweep just finished.
- IDLE:
  - Start=1, Num_steps≠0: latch Num_steps; step_count←0; x=y=0; busy←1; next state COLLIDE with phase=1.
  - Start=1, Num_steps=0: done←1 for one cycle; stay IDLE; busy stays 0.
  - Start while busy: ignored.
- COLLIDE / STREAM:
  - Each cycle with Stall=0: x increments; at x=GRID_W-1, x wraps to 0 and y increments.
  - At address GRID_DIM-1 with Stall=0: go to DRAIN and load the drain counter with MEM_LATENCY.
- BC: visits only the 4*GRID_W-4 boundary nodes, in raster order.
  - Rows y=0 and y=GRID_W-1: every x.
  - Middle rows: x=0, then jump directly to x=GRID_W-1.
  - Last node is GRID_DIM-1 → DRAIN.
- Stall=1 in a sweep: address, x and y hold; addr_valid=0. Stall is ignored in DRAIN and IDLE.
- DRAIN:
  - Counter decrements every cycle; addr_valid=0.
  - When the counter reaches 1, the next state follows the phase just finished:
    - after COLLIDE → STREAM.
    - after STREAM → BC.
    - after BC: bank_sel toggles and step_count increments (same edge); if the new step_count equals Num_steps → IDLE with busy←0 and done←1 for one cycle, else → COLLIDE.
  - x and y are zeroed on every sweep entry.
- address is 0 in IDLE.
- Latency: Start accepted at edge 0 → address 0 valid in cycle 1.
  - One timestep with no stalls = 2*GRID_DIM + (4*GRID_W-4) + 3*MEM_LATENCY cycles.
- Reset mid-run: immediate return to IDLE.
  - bank_sel returns to 0; software must reload both banks.

Optional Feature:
- Macro: LBM_SCHED_ABORT_EN.
- Defined: adds input Abort (1 bit).
  - Abort=1 in any non-IDLE state → DRAIN for MEM_LATENCY cycles, then IDLE.
  - busy←0; done stays 0; bank_sel and step_count are not updated for the partial step.
  - Abort in IDLE: no effect.
  - Abort takes priority over Stall and over sweep completion.
- Undefined: no Abort port; no abort path in the FSM.

Test Plan:
- Defaults, Num_steps=1, no stall, Start at edge 0 → collide cycles 1–256 (address 0..255), drain 257–258, stream 259–514, drain 515–516, bc 517–576 (60 addresses, e.g. 0..15, 16, 31, 32, …, 240..255), drain 577–578; done=1, busy=0, bank_sel=1, step_count=1 in cycle 579.
- Num_steps=3 → phase sequence 1,2,3 repeats three times; bank_sel reads 1,0,1 after each step; exactly one done pulse; step_count=3.
- Stall high for 5 cycles while address=100 in COLLIDE → address holds at 100, addr_valid=0 for those 5 cycles; run completes 5 cycles later than the unstalled run; no address skipped or repeated.
- Start with Num_steps=0 → done pulses one cycle after; busy never rises. Start pulsed again mid-run → ignored; step count unchanged.
- Reset asserted asynchronously mid-STREAM (between clock edges) → all outputs 0 immediately; after release, a fresh Start runs normally from address 0.
- LBM_SCHED_ABORT_EN defined, Abort in BC at address 31 → 2 drain cycles, then IDLE; done=0; bank_sel and step_count unchanged.
